// File: rtl/hcsr04_pkg.sv
// Shared HC-SR04 timing constants and responder state type.
// Imported by the echo responder and by sensor_driver.
package hcsr04_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        BURST,
        ECHO,
        HOLDOFF
    } resp_state_t;

    localparam int DEF_CLK_FREQ       = 50_000_000;
    localparam int DEF_TRIG_MIN_US    = 10;
    localparam int DEF_BURST_DELAY_US = 250;
    localparam int US_PER_CM          = 58;
    localparam int MAX_CM             = 400;
    localparam int TIMEOUT_US         = 38000;
    localparam int DEF_HOLDOFF_US     = 10000;
    localparam int DIST_W             = 9;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchroniser for a single asynchronous level.
// Ports: clk, rst (async, active-high, clears to 0), d (async in), q (synced out).
module bit_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ultrasonic_echo_responder.sv
// Sensor-side HC-SR04 model: validates the trigger width, waits the burst
// delay, then returns an echo whose width encodes distance_cm.
// Ports: clk, rst (async, active-high), trig (async in), distance_cm [8:0],
//        echo, busy, trig_accepted (1-cycle), out_of_range (latched).
module ultrasonic_echo_responder #(
    parameter int CLK_FREQ       = hcsr04_pkg::DEF_CLK_FREQ,
    parameter int TRIG_MIN_US    = hcsr04_pkg::DEF_TRIG_MIN_US,
    parameter int BURST_DELAY_US = hcsr04_pkg::DEF_BURST_DELAY_US,
    parameter int US_PER_CM      = hcsr04_pkg::US_PER_CM,
    parameter int MAX_CM         = hcsr04_pkg::MAX_CM,
    parameter int TIMEOUT_US     = hcsr04_pkg::TIMEOUT_US,
    parameter int HOLDOFF_US     = hcsr04_pkg::DEF_HOLDOFF_US
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trig,
    input  logic [8:0] distance_cm,
    output logic       echo,
    output logic       busy,
    output logic       trig_accepted,
    output logic       out_of_range
);

    import hcsr04_pkg::*;

    localparam int CYC_US      = CLK_FREQ / 1_000_000;
    localparam int TRIG_CYC    = TRIG_MIN_US * CYC_US;
    localparam int BURST_CYC   = BURST_DELAY_US * CYC_US;
    localparam int CM_CYC      = US_PER_CM * CYC_US;
    localparam int TIMEOUT_CYC = TIMEOUT_US * CYC_US;
    localparam int HOLD_CYC    = HOLDOFF_US * CYC_US;
    localparam int INRANGE_CYC = MAX_CM * CM_CYC;

    localparam int MAX_CYC = max_of(max_of(TIMEOUT_CYC, INRANGE_CYC),
                                    max_of(max_of(HOLD_CYC, BURST_CYC),
                                           TRIG_CYC));
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int CM_W    = $clog2(CM_CYC + 1);
    localparam int PW      = DIST_W + CM_W;

    localparam logic [CNT_W-1:0]  ONE_K     = CNT_W'(1);
    localparam logic [CNT_W-1:0]  TRIG_K    = CNT_W'(TRIG_CYC);
    localparam logic [CNT_W-1:0]  BURST_K   = CNT_W'(BURST_CYC - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_K = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0]  HOLD_K    = CNT_W'(HOLD_CYC);
    localparam logic [DIST_W-1:0] MAX_CM_K  = DIST_W'(MAX_CM);
    localparam logic [PW-1:0]     CM_K      = PW'(CM_CYC);

    if (CYC_US < 1) begin : g_bad_clk
        $error("CLK_FREQ must be at least 1 MHz");
    end
    if (BURST_CYC < 2 || HOLD_CYC < 1 || TRIG_CYC < 1) begin : g_bad_time
        $error("burst needs >= 2 cycles, holdoff and trigger >= 1");
    end
    if (TIMEOUT_CYC < 1 || CM_CYC < 1) begin : g_bad_echo
        $error("echo timing constants must be non-zero");
    end
    if (MAX_CM > (1 << DIST_W) - 1) begin : g_bad_cm
        $error("MAX_CM does not fit distance_cm");
    end
    if (INRANGE_CYC >= (1 << CNT_W) || TIMEOUT_CYC >= (1 << CNT_W)) begin : g_bad_w
        $error("echo length truncated by counter width");
    end

    logic              trig_s;
    resp_state_t       state;
    logic [CNT_W-1:0]  cnt;
    logic [PW-1:0]     prod_q;
    logic [CNT_W-1:0]  echo_len;
    logic              oor_now;

    bit_sync u_trig_sync (
        .clk (clk),
        .rst (rst),
        .d   (trig),
        .q   (trig_s)
    );

    assign oor_now = (distance_cm == '0) || (distance_cm > MAX_CM_K);

    // prod_q is only consumed when the latched range flag is clear,
    // so the in-range product always fits the counter.
    assign echo_len = out_of_range ? TIMEOUT_K : CNT_W'(prod_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            prod_q        <= '0;
            echo          <= 1'b0;
            busy          <= 1'b0;
            trig_accepted <= 1'b0;
            out_of_range  <= 1'b0;
        end else begin
            trig_accepted <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (trig_s) begin
                        state <= TRIG;
                        cnt   <= ONE_K;
                    end
                end
                TRIG: begin
                    // In TRIG the previous synced sample was high, so a
                    // low sample here is the falling edge.
                    if (trig_s) begin
                        if (cnt < TRIG_K) begin
                            cnt <= cnt + ONE_K;
                        end
                    end else if (cnt >= TRIG_K) begin
                        state         <= BURST;
                        cnt           <= BURST_K;
                        busy          <= 1'b1;
                        trig_accepted <= 1'b1;
                        out_of_range  <= oor_now;
                        prod_q        <= PW'(distance_cm) * CM_K;
                    end else begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end
                BURST: begin
                    if (cnt == ONE_K) begin
                        state <= ECHO;
                        echo  <= 1'b1;
                        cnt   <= echo_len;
                    end else begin
                        cnt <= cnt - ONE_K;
                    end
                end
                ECHO: begin
                    if (cnt == ONE_K) begin
                        state <= HOLDOFF;
                        echo  <= 1'b0;
                        cnt   <= HOLD_K;
                    end else begin
                        cnt <= cnt - ONE_K;
                    end
                end
                HOLDOFF: begin
                    if (cnt == ONE_K) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - ONE_K;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    echo  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
